// File: rtl/jzjpcc_memory.sv
// jzjpcc_memory
// -------------
// Memory stage of the jzjpcc pipeline, sitting directly after execute.
// Non-memory instructions flow straight through to the writeback registers
// in one cycle. Loads and stores are decoded, checked for a legal funct3 and
// natural alignment, and then issued to data memory over a registered
// request / acknowledge handshake while the rest of the pipeline is stalled.
// Illegal or misaligned accesses never reach memory; they produce a one-cycle
// accessFault pulse and a writeback bubble instead.
//
// Ports
//   clock                    pipeline clock, rising edge
//   reset                    asynchronous reset, active-low
//   aluResult_memory         ALU result / effective address from execute
//   rdWriteEnable_memory     instruction writes rd
//   rdAddr_memory            destination register
//   memRead_memory           instruction is a load (wins if memWrite also set)
//   memWrite_memory          instruction is a store
//   funct3_memory            RISC-V funct3: access size and signedness
//   storeData_memory         rs2 value for stores
//   dmemReq                  registered data memory request
//   dmemWriteEnable          registered: request is a store
//   dmemAddr                 registered word address (byte address [31:2])
//   dmemWriteData            registered lane-replicated store data
//   dmemByteMask             registered byte lanes touched by the access
//   dmemAck                  memory completes the request this cycle
//   dmemReadData             read word, valid while dmemAck is high
//   stall                    combinational hold for execute and earlier stages
//   accessFault              registered one-cycle pulse on a rejected access
//   rdWriteData_writeback    value for the register file
//   rdAddr_writeback         destination register of the retiring instruction
//   rdWriteEnable_writeback  register file write strobe

module jzjpcc_memory (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] aluResult_memory,
  input  logic        rdWriteEnable_memory,
  input  logic [4:0]  rdAddr_memory,
  input  logic        memRead_memory,
  input  logic        memWrite_memory,
  input  logic [2:0]  funct3_memory,
  input  logic [31:0] storeData_memory,
  output logic        dmemReq,
  output logic        dmemWriteEnable,
  output logic [29:0] dmemAddr,
  output logic [31:0] dmemWriteData,
  output logic [3:0]  dmemByteMask,
  input  logic        dmemAck,
  input  logic [31:0] dmemReadData,
  output logic        stall,
  output logic        accessFault,
  output logic [31:0] rdWriteData_writeback,
  output logic [4:0]  rdAddr_writeback,
  output logic        rdWriteEnable_writeback
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  state_t nextState;

  // Decoded view of the instruction currently presented by execute
  logic        isMemOp;
  logic        isLoad;
  logic        isStore;
  logic [1:0]  byteOffset;
  logic        sizeByte;
  logic        sizeHalf;
  logic        sizeWord;
  logic        funct3Legal;
  logic        aligned;
  logic [3:0]  requestMask;
  logic [31:0] requestData;

  // FSM strobes consumed by the datapath registers
  logic        startAccess;
  logic        rejectAccess;
  logic        passThrough;
  logic        completeAccess;

  // Context of the outstanding access, captured when the request is issued
  logic        pendingIsLoad;
  logic [1:0]  pendingOffset;
  logic [2:0]  pendingFunct3;

  // Load result after lane selection and extension
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;

  // Instruction decode: classify the access, check funct3 legality and
  // natural alignment, and precompute the byte mask and replicated store
  // data that will be registered onto the memory bus. A load with memWrite
  // also set is decoded purely as a load.
  always_comb begin
    isMemOp    = memRead_memory | memWrite_memory;
    isLoad     = memRead_memory;
    isStore    = memWrite_memory & ~memRead_memory;
    byteOffset = aluResult_memory[1:0];
    sizeByte   = (funct3_memory[1:0] == 2'b00);
    sizeHalf   = (funct3_memory[1:0] == 2'b01);
    sizeWord   = (funct3_memory[1:0] == 2'b10);

    funct3Legal = 1'b0;
    if (isLoad) begin
      case (funct3_memory)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3Legal = 1'b1;
        default:                                funct3Legal = 1'b0;
      endcase
    end else begin
      case (funct3_memory)
        3'b000, 3'b001, 3'b010: funct3Legal = 1'b1;
        default:                funct3Legal = 1'b0;
      endcase
    end

    aligned = sizeByte
            | (sizeHalf & ~byteOffset[0])
            | (sizeWord & (byteOffset == 2'b00));

    if (sizeWord) begin
      requestMask = 4'b1111;
    end else if (sizeHalf) begin
      requestMask = 4'b0011 << {byteOffset[1], 1'b0};
    end else begin
      requestMask = 4'b0001 << byteOffset;
    end

    // Replicating the store value across all lanes lets memory pick it up
    // from whichever lanes the mask enables, without a shifter here.
    if (sizeWord) begin
      requestData = storeData_memory;
    end else if (sizeHalf) begin
      requestData = {2{storeData_memory[15:0]}};
    end else begin
      requestData = {4{storeData_memory[7:0]}};
    end
  end

  // State register for the access FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and stall logic. In IDLE a good memory op stalls for the
  // cycle it is being issued; in ACCESS the pipeline is held until the
  // acknowledge arrives. Acknowledges seen in IDLE are deliberately ignored.
  always_comb begin
    nextState      = state;
    stall          = 1'b0;
    startAccess    = 1'b0;
    rejectAccess   = 1'b0;
    passThrough    = 1'b0;
    completeAccess = 1'b0;
    case (state)
      IDLE: begin
        if (isMemOp) begin
          if (funct3Legal && aligned) begin
            startAccess = 1'b1;
            stall       = 1'b1;
            nextState   = ACCESS;
          end else begin
            rejectAccess = 1'b1;
          end
        end else begin
          passThrough = 1'b1;
        end
      end
      ACCESS: begin
        stall = ~dmemAck;
        if (dmemAck) begin
          completeAccess = 1'b1;
          nextState      = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Load alignment and extension. The lane is chosen from the offset that
  // was registered with the request, not from the live address input.
  always_comb begin
    case (pendingOffset)
      2'd0:    loadByte = dmemReadData[7:0];
      2'd1:    loadByte = dmemReadData[15:8];
      2'd2:    loadByte = dmemReadData[23:16];
      default: loadByte = dmemReadData[31:24];
    endcase
    loadHalf = pendingOffset[1] ? dmemReadData[31:16] : dmemReadData[15:0];
    case (pendingFunct3)
      3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadValue = {24'd0, loadByte};
      3'b101:  loadValue = {16'd0, loadHalf};
      default: loadValue = dmemReadData;
    endcase
  end

  // Memory bus registers. The request fields are loaded once at issue and
  // then held untouched until the acknowledge edge, so memory sees a stable
  // transaction for as many wait cycles as it needs. An asynchronous reset
  // drops the request immediately and abandons any outstanding access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmemReq         <= 1'b0;
      dmemWriteEnable <= 1'b0;
      dmemAddr        <= 30'd0;
      dmemWriteData   <= 32'd0;
      dmemByteMask    <= 4'd0;
      pendingIsLoad   <= 1'b0;
      pendingOffset   <= 2'd0;
      pendingFunct3   <= 3'd0;
    end else begin
      if (startAccess) begin
        dmemReq         <= 1'b1;
        dmemWriteEnable <= isStore;
        dmemAddr        <= aluResult_memory[31:2];
        dmemWriteData   <= requestData;
        dmemByteMask    <= requestMask;
        pendingIsLoad   <= isLoad;
        pendingOffset   <= byteOffset;
        pendingFunct3   <= funct3_memory;
      end else if (completeAccess) begin
        dmemReq         <= 1'b0;
        dmemWriteEnable <= 1'b0;
      end
    end
  end

  // Writeback registers and fault pulse. Every edge retires something into
  // writeback: the pass-through ALU value, a completed load, or a bubble
  // (write enable low) for issue cycles, wait cycles, stores and rejected
  // accesses. The rd address always follows the instruction in memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdWriteData_writeback   <= 32'd0;
      rdAddr_writeback        <= 5'd0;
      rdWriteEnable_writeback <= 1'b0;
      accessFault             <= 1'b0;
    end else begin
      accessFault      <= rejectAccess;
      rdAddr_writeback <= rdAddr_memory;
      if (passThrough) begin
        rdWriteData_writeback   <= aluResult_memory;
        rdWriteEnable_writeback <= rdWriteEnable_memory;
      end else if (completeAccess && pendingIsLoad) begin
        rdWriteData_writeback   <= loadValue;
        rdWriteEnable_writeback <= rdWriteEnable_memory;
      end else begin
        rdWriteEnable_writeback <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory.sv
// tb_jzjpcc_memory
// ----------------
// Self-checking bench for jzjpcc_memory. A transaction-level model tracks the
// one outstanding memory access and a word-addressed backing memory, and a
// compare process checks every DUT output against it on each falling edge.
// Directed sequences pin the model with hand-computed values, then a block of
// random instructions exercises the mix of ALU ops, loads, stores and faults.

module tb_jzjpcc_memory;

  logic        clock;
  logic        reset;
  logic [31:0] aluResult_memory;
  logic        rdWriteEnable_memory;
  logic [4:0]  rdAddr_memory;
  logic        memRead_memory;
  logic        memWrite_memory;
  logic [2:0]  funct3_memory;
  logic [31:0] storeData_memory;
  logic        dmemReq;
  logic        dmemWriteEnable;
  logic [29:0] dmemAddr;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteMask;
  logic        dmemAck;
  logic [31:0] dmemReadData;
  logic        stall;
  logic        accessFault;
  logic [31:0] rdWriteData_writeback;
  logic [4:0]  rdAddr_writeback;
  logic        rdWriteEnable_writeback;

  jzjpcc_memory dut (
    .clock                   (clock),
    .reset                   (reset),
    .aluResult_memory        (aluResult_memory),
    .rdWriteEnable_memory    (rdWriteEnable_memory),
    .rdAddr_memory           (rdAddr_memory),
    .memRead_memory          (memRead_memory),
    .memWrite_memory         (memWrite_memory),
    .funct3_memory           (funct3_memory),
    .storeData_memory        (storeData_memory),
    .dmemReq                 (dmemReq),
    .dmemWriteEnable         (dmemWriteEnable),
    .dmemAddr                (dmemAddr),
    .dmemWriteData           (dmemWriteData),
    .dmemByteMask            (dmemByteMask),
    .dmemAck                 (dmemAck),
    .dmemReadData            (dmemReadData),
    .stall                   (stall),
    .accessFault             (accessFault),
    .rdWriteData_writeback   (rdWriteData_writeback),
    .rdAddr_writeback        (rdAddr_writeback),
    .rdWriteEnable_writeback (rdWriteEnable_writeback)
  );

  int assertCount = 0;
  int failCount   = 0;
  int stallCount  = 0;
  int opCycles    = 0;

  // First request seen by the most recent applyStimulus call
  logic        sawReq;
  logic        reqWe;
  logic [29:0] reqAddr;
  logic [3:0]  reqMask;
  logic [31:0] reqWdata;

  // Backing memory, word addressed
  logic [31:0] mem [0:1023];

  // Transaction model state
  logic        pendValid   = 1'b0;
  logic        pendIsLoad  = 1'b0;
  logic [29:0] pendWord    = 30'd0;
  int          pendLane    = 0;
  int          pendBytes   = 0;
  logic        pendSigned  = 1'b0;
  logic        pendRdWe    = 1'b0;
  logic        expReq      = 1'b0;
  logic        expWe       = 1'b0;
  logic [29:0] expAddr     = 30'd0;
  logic [3:0]  expMask     = 4'd0;
  logic [31:0] expWdata    = 32'd0;
  logic        expFault    = 1'b0;
  logic [31:0] expWbData   = 32'd0;
  logic [4:0]  expWbAddr   = 5'd0;
  logic        expWbWe     = 1'b0;
  logic        wbDataKnown = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int accessBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit accessOk(input logic isRead, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int n;
    if (isRead) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else        legal = (f3 <= 3'd2);
    n = accessBytes(f3);
    if (!legal || n == 0) return 1'b0;
    return (int'(addr[1:0]) % n) == 0;
  endfunction

  function automatic logic [3:0] laneMask(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = accessBytes(f3);
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int n;
    n = accessBytes(f3);
    w = 32'd0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = rs2[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] loadValue(input logic [31:0] word, input int lane, input int n, input logic sgn);
    longint v;
    v = longint'({32'd0, word});
    v = (v >> (8 * lane)) % (longint'(1) << (8 * n));
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  function automatic logic expectedStall();
    if (pendValid) return !dmemAck;
    if (memRead_memory || memWrite_memory) return accessOk(memRead_memory, funct3_memory, aluResult_memory);
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one instruction is considered per rising edge. An
  // outstanding access completes on an acknowledged edge; otherwise a new
  // instruction either passes through, is rejected, or opens an access.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pendValid   <= 1'b0;
      expReq      <= 1'b0;
      expWe       <= 1'b0;
      expAddr     <= 30'd0;
      expMask     <= 4'd0;
      expWdata    <= 32'd0;
      expFault    <= 1'b0;
      expWbData   <= 32'd0;
      expWbAddr   <= 5'd0;
      expWbWe     <= 1'b0;
      wbDataKnown <= 1'b1;
    end else begin
      expFault    <= 1'b0;
      expWbAddr   <= rdAddr_memory;
      wbDataKnown <= 1'b0;
      if (pendValid) begin
        expWbWe <= 1'b0;
        if (dmemAck) begin
          pendValid <= 1'b0;
          expReq    <= 1'b0;
          if (pendIsLoad) begin
            expWbData   <= loadValue(mem[pendWord[9:0]], pendLane, pendBytes, pendSigned);
            expWbWe     <= pendRdWe;
            wbDataKnown <= 1'b1;
          end else begin
            mem[pendWord[9:0]] <= mergeStore(mem[pendWord[9:0]], expMask, expWdata);
          end
        end
      end else if (memRead_memory || memWrite_memory) begin
        expWbWe <= 1'b0;
        if (accessOk(memRead_memory, funct3_memory, aluResult_memory)) begin
          pendValid  <= 1'b1;
          pendIsLoad <= memRead_memory;
          pendWord   <= aluResult_memory[31:2];
          pendLane   <= int'(aluResult_memory[1:0]);
          pendBytes  <= accessBytes(funct3_memory);
          pendSigned <= !funct3_memory[2];
          pendRdWe   <= rdWriteEnable_memory;
          expReq     <= 1'b1;
          expWe      <= !memRead_memory;
          expAddr    <= aluResult_memory[31:2];
          expMask    <= laneMask(funct3_memory, aluResult_memory);
          expWdata   <= replicate(funct3_memory, storeData_memory);
        end else begin
          expFault <= 1'b1;
        end
      end else begin
        expWbData   <= aluResult_memory;
        expWbWe     <= rdWriteEnable_memory;
        wbDataKnown <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge
  always @(negedge clock) begin
    if (reset) begin
      if (stall === 1'b1) stallCount++;
      checkOutput("stall", stall, expectedStall());
      checkOutput("dmemReq", dmemReq, expReq);
      checkOutput("accessFault", accessFault, expFault);
      checkOutput("rdWriteEnable_writeback", rdWriteEnable_writeback, expWbWe);
      checkOutput("rdAddr_writeback", rdAddr_writeback, expWbAddr);
      if (wbDataKnown) checkOutput("rdWriteData_writeback", rdWriteData_writeback, expWbData);
      if (expReq) begin
        checkOutput("dmemWriteEnable", dmemWriteEnable, expWe);
        checkOutput("dmemAddr", dmemAddr, expAddr);
        checkOutput("dmemByteMask", dmemByteMask, expMask);
        checkOutput("dmemWriteData", dmemWriteData, expWdata);
      end
    end
  end

  // Presents one instruction and plays memory for it: inputs are held until
  // the model has no access outstanding, acknowledging after 'waits' cycles.
  task automatic applyStimulus(input logic rdOp, input logic wrOp, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic we, input int waits);
    int waitLeft;
    memRead_memory       = rdOp;
    memWrite_memory      = wrOp;
    funct3_memory        = f3;
    aluResult_memory     = alu;
    storeData_memory     = rs2;
    rdAddr_memory        = rd;
    rdWriteEnable_memory = we;
    dmemAck              = 1'($urandom_range(0, 1));
    dmemReadData         = $urandom;
    waitLeft             = waits;
    stallCount           = 0;
    sawReq               = 1'b0;
    opCycles             = 0;
    do begin
      @(posedge clock);
      #1;
      opCycles++;
      if (dmemReq === 1'b1 && !sawReq) begin
        sawReq   = 1'b1;
        reqWe    = dmemWriteEnable;
        reqAddr  = dmemAddr;
        reqMask  = dmemByteMask;
        reqWdata = dmemWriteData;
      end
      if (pendValid) begin
        dmemAck      = (waitLeft == 0);
        dmemReadData = mem[pendWord[9:0]];
        if (waitLeft > 0) waitLeft--;
      end else begin
        dmemAck      = 1'($urandom_range(0, 1));
        dmemReadData = $urandom;
      end
    end while (pendValid && opCycles < 64);
    checkOutput("reqClearedAfterOp", dmemReq, 1'b0);
  endtask

  logic       faultRd [3] = '{1'b1, 1'b0, 1'b1};
  logic [2:0] faultF3 [3] = '{3'b010, 3'b001, 3'b011};
  logic [31:0] faultAd [3] = '{32'h2, 32'h1, 32'h0};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 ^ (i * 32'h9E37_79B1);
    reset                = 1'b0;
    aluResult_memory     = 32'd0;
    rdWriteEnable_memory = 1'b0;
    rdAddr_memory        = 5'd0;
    memRead_memory       = 1'b0;
    memWrite_memory      = 1'b0;
    funct3_memory        = 3'd0;
    storeData_memory     = 32'd0;
    dmemAck              = 1'b0;
    dmemReadData         = 32'd0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetDmemReq", dmemReq, 1'b0);
    checkOutput("resetRdWriteEnable", rdWriteEnable_writeback, 1'b0);
    checkOutput("resetRdWriteData", rdWriteData_writeback, 32'd0);
    checkOutput("resetAccessFault", accessFault, 1'b0);
    checkOutput("resetStall", stall, 1'b0);
    reset = 1'b1;

    // LB with two wait states
    mem[10'h40] = 32'h80FF_7F01;
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 2);
    checkOutput("lbReqAddr", reqAddr, 30'h40);
    checkOutput("lbReqMask", reqMask, 4'b1000);
    checkOutput("lbStallCycles", stallCount, 3);
    checkOutput("lbData", rdWriteData_writeback, 32'hFFFF_FF80);
    checkOutput("lbWriteEnable", rdWriteEnable_writeback, 1'b1);
    checkOutput("lbRdAddr", rdAddr_writeback, 5'd7);

    // LHU, zero-wait
    mem[10'h80] = 32'hBEEF_1234;
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 5'd9, 1'b1, 0);
    checkOutput("lhuData", rdWriteData_writeback, 32'h0000_BEEF);
    checkOutput("lhuWriteEnable", rdWriteEnable_writeback, 1'b1);
    checkOutput("lhuCycles", opCycles, 2);
    checkOutput("lhuStallCycles", stallCount, 1);

    // SH
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'hAAAA_5678, 5'd3, 1'b1, 1);
    checkOutput("shReqWe", reqWe, 1'b1);
    checkOutput("shReqAddr", reqAddr, 30'h1);
    checkOutput("shReqMask", reqMask, 4'b1100);
    checkOutput("shReqData", reqWdata, 32'h5678_5678);
    checkOutput("shWriteEnable", rdWriteEnable_writeback, 1'b0);

    // Faults: misaligned LW, misaligned SH, illegal funct3 load
    for (int i = 0; i < 3; i++) begin
      applyStimulus(faultRd[i], !faultRd[i], faultF3[i], faultAd[i], 32'h1234_5678, 5'd4, 1'b1, 0);
      checkOutput("faultPulse", accessFault, 1'b1);
      checkOutput("faultNoReq", sawReq, 1'b0);
      checkOutput("faultNoStall", stallCount, 0);
      checkOutput("faultNoRdWrite", rdWriteEnable_writeback, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h5555_AAAA, 32'd0, 5'd1, 1'b1, 0);
    checkOutput("faultPulseEnds", accessFault, 1'b0);

    // Back-to-back SW then LW at 0x10
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd12, 1'b1, 0);
    checkOutput("b2bLoadData", rdWriteData_writeback, 32'hCAFE_F00D);

    // Reset in the middle of an access
    memRead_memory       = 1'b1;
    memWrite_memory      = 1'b0;
    funct3_memory        = 3'b010;
    aluResult_memory     = 32'h0000_0020;
    rdAddr_memory        = 5'd6;
    rdWriteEnable_memory = 1'b1;
    dmemAck              = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midAccessReq", dmemReq, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncResetReq", dmemReq, 1'b0);
    checkOutput("asyncResetWbWe", rdWriteEnable_writeback, 1'b0);
    checkOutput("asyncResetWbData", rdWriteData_writeback, 32'd0);
    checkOutput("asyncResetWbAddr", rdAddr_writeback, 5'd0);
    checkOutput("asyncResetFault", accessFault, 1'b0);
    @(posedge clock);
    #3;
    memRead_memory       = 1'b0;
    aluResult_memory     = 32'h1234_5678;
    rdAddr_memory        = 5'd5;
    rdWriteEnable_memory = 1'b1;
    stallCount           = 0;
    reset                = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("postResetData", rdWriteData_writeback, 32'h1234_5678);
    checkOutput("postResetRdAddr", rdAddr_writeback, 5'd5);
    checkOutput("postResetWe", rdWriteEnable_writeback, 1'b1);
    checkOutput("postResetNoStall", stallCount, 0);

    // Random instruction mix
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic rdOp;
      logic wrOp;
      logic [2:0] f3;
      logic [31:0] alu;
      kind = int'($urandom_range(0, 9));
      alu  = 32'($urandom_range(0, 63));
      if (kind <= 3) begin
        rdOp = 1'b0; wrOp = 1'b0; f3 = 3'($urandom_range(0, 7)); alu = $urandom;
      end else if (kind <= 6) begin
        rdOp = 1'b1; wrOp = 1'b0;
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else if (kind <= 8) begin
        rdOp = 1'b0; wrOp = 1'b1; f3 = 3'($urandom_range(0, 2));
      end else begin
        rdOp = 1'($urandom_range(0, 1)); wrOp = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
      end
      applyStimulus(rdOp, wrOp, f3, alu, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
